axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging NUM_SRC AXI-Stream slaves onto one registered master port.
// Each grant carries up to BURST_LEN beats. Arbitration costs one idle cycle.

module axis_rr_arbiter_chk #(
  parameter int NUM_SRC = 4
) (
  input logic               clk,
  input logic               rst_n,
  input logic [NUM_SRC-1:0] tready
);
  a_tready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(tready));
endmodule

module axis_rr_arbiter #(
  parameter int  DATA_WIDTH = 8,
  parameter int  NUM_SRC    = 4,
  parameter int  BURST_LEN  = 4,
  localparam int IDW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            S_AXIS_TVALID,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic [NUM_SRC-1:0]            S_AXIS_TREADY,
  output logic                          M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic [IDW-1:0]                M_AXIS_TID,
  input  logic                          M_AXIS_TREADY
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t                state_r;
  logic [IDW-1:0]        grant_r;
  logic [IDW-1:0]        last_r;
  logic [7:0]            beat_cnt_r;
  logic                  m_valid_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic [IDW-1:0]        m_tid_r;

  logic                  slot_free_s;
  logic                  valid_sel_s;
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] data_sel_s;
  logic [NUM_SRC-1:0]    tready_s;

  // Walk last+NUM_SRC down to last+1 so the nearest requester after last is the final winner.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                             input logic [IDW-1:0]     lst);
    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    win = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = IDW'((int'(lst) + k) % NUM_SRC);
      win = req[idx] ? idx : win;
    end
    return win;
  endfunction

  assign slot_free_s = !m_valid_r || M_AXIS_TREADY;

  // Select the granted source and offer ready only to it, only when the output slot can take a beat.
  always_comb begin
    valid_sel_s = 1'b0;
    data_sel_s  = '0;
    tready_s    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_r == IDW'(i)) begin
        valid_sel_s = S_AXIS_TVALID[i];
        data_sel_s  = S_AXIS_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
        tready_s[i] = (state_r == ST_GRANT) && slot_free_s;
      end else begin
        tready_s[i] = 1'b0;
      end
    end
  end

  assign xfer_s = valid_sel_s && (state_r == ST_GRANT) && slot_free_s;

  // Arbitration FSM plus the single-entry master output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= '0;
      last_r     <= IDW'(NUM_SRC - 1);
      beat_cnt_r <= 8'd0;
      m_valid_r  <= 1'b0;
      m_data_r   <= '0;
      m_tid_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|S_AXIS_TVALID) begin
            grant_r    <= rr_pick(S_AXIS_TVALID, last_r);
            beat_cnt_r <= 8'd0;
            state_r    <= ST_GRANT;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (xfer_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
            if (beat_cnt_r == 8'(BURST_LEN - 1)) begin
              state_r <= ST_IDLE;
              last_r  <= grant_r;
            end else begin
              state_r <= ST_GRANT;
            end
          end else if (slot_free_s) begin
            // Granted source went quiet while the slot was open: release early.
            state_r <= ST_IDLE;
            last_r  <= grant_r;
          end else begin
            state_r <= ST_GRANT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (xfer_s) begin
        m_valid_r <= 1'b1;
        m_data_r  <= data_sel_s;
        m_tid_r   <= grant_r;
      end else if (M_AXIS_TREADY) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
    end
  end

  assign S_AXIS_TREADY = tready_s;
  assign M_AXIS_TVALID = m_valid_r;
  assign M_AXIS_TDATA  = m_data_r;
  assign M_AXIS_TID    = m_tid_r;

  axis_rr_arbiter_chk #(.NUM_SRC(NUM_SRC)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .tready (tready_s)
  );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios plus a randomized phase, checked against
// per-source expected-beat queues and hand-derived sequences.

module tb_axis_rr_arbiter;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int BL = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NS-1:0]    s_valid, s_ready;
  logic [NS*DW-1:0] s_data;
  logic             m_valid, m_ready;
  logic [DW-1:0]    m_data;
  logic [1:0]       m_tid;
  logic [NS-1:0]    s1_valid, s1_ready;
  logic [NS*DW-1:0] s1_data;
  logic             m1_valid, m1_ready;
  logic [DW-1:0]    m1_data;
  logic [1:0]       m1_tid;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit [NS-1:0] want;
  bit rnd, u1_on;
  int remaining[NS];
  int nxt[NS];
  int base[NS];
  int exp_q[NS][$];
  int out_tid[$], out_dat[$], out_cyc[$];
  int u1_tid[$], u1_dat[$], u1_cyc[$];

  always #5 clk = ~clk;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .BURST_LEN(BL)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TDATA(s_data), .S_AXIS_TREADY(s_ready),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TDATA(m_data), .M_AXIS_TID(m_tid),
    .M_AXIS_TREADY(m_ready)
  );

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .BURST_LEN(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_TVALID(s1_valid), .S_AXIS_TDATA(s1_data), .S_AXIS_TREADY(s1_ready),
    .M_AXIS_TVALID(m1_valid), .M_AXIS_TDATA(m1_data), .M_AXIS_TID(m1_tid),
    .M_AXIS_TREADY(m1_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  // One clock: drive sources, sample just before the edge, update the reference after it.
  task automatic cycle();
    logic [NS-1:0] hs;
    logic mhs, stall, u1v;
    logic [DW-1:0] md, u1d;
    logic [1:0] mt, u1t;
    int e;
    for (int i = 0; i < NS; i++) begin
      s_valid[i] = want[i] && (remaining[i] > 0) && (!rnd || ($urandom_range(3, 0) != 0));
      s_data[i*DW +: DW] = DW'((base[i] + nxt[i]) % 256);
    end
    #2;
    hs = s_valid & s_ready;
    mhs = m_valid && m_ready;
    stall = m_valid && !m_ready;
    md = m_data; mt = m_tid;
    u1v = m1_valid; u1d = m1_data; u1t = m1_tid;
    check("onehot0", 32'($onehot0(s_ready)), 32'd1);
    check("onehot0_b1", 32'($onehot0(s1_ready)), 32'd1);
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        exp_q[i].push_back((base[i] + nxt[i]) % 256);
        nxt[i]++;
        remaining[i]--;
      end
    end
    if (mhs) begin
      out_tid.push_back(int'(mt));
      out_dat.push_back(int'(md));
      out_cyc.push_back(cyc);
      check("sb_pending", 32'(exp_q[mt].size() != 0), 32'd1);
      if (exp_q[mt].size() != 0) begin
        e = exp_q[mt].pop_front();
        check("sb_data", 32'(md), 32'(e));
      end
    end
    if (stall) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'(m_data), 32'(md));
      check("hold_tid", 32'(m_tid), 32'(mt));
    end
    if (u1_on && u1v) begin
      u1_tid.push_back(int'(u1t));
      u1_dat.push_back(int'(u1d));
      u1_cyc.push_back(cyc);
    end
  endtask

  task automatic run_outputs(input string tag, input int n, input int budget);
    for (int b = 0; b < budget && out_tid.size() < n; b++) cycle();
    check({tag, "_count"}, 32'(out_tid.size() >= n), 32'd1);
  endtask

  // Assert reset mid-cycle, confirm outputs clear at once, and reset the reference model.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_tid", 32'(m_tid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_b1_valid", 32'(m1_valid), 32'd0);
    check("rst_b1_ready", 32'(s1_ready), 32'd0);
    want = '0; rnd = 1'b0; s_valid = '0; m_ready = 1'b1;
    for (int i = 0; i < NS; i++) begin
      remaining[i] = 0; nxt[i] = 0; base[i] = 0;
      exp_q[i].delete();
    end
    out_tid.delete(); out_dat.delete(); out_cyc.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int sent;
    s_valid = '0; s_data = '0; m_ready = 1'b1;
    s1_valid = 4'hF; s1_data = 32'h33323130; m1_ready = 1'b1;
    want = '0; rnd = 1'b0; u1_on = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // BURST_LEN=1 instance: one beat per grant, rotating, with a bubble between grants.
    u1_on = 1'b1;
    repeat (12) cycle();
    u1_on = 1'b0;
    check("b1_beats", 32'(u1_tid.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("b1_tid", 32'(qget(u1_tid, k)), 32'(k % 4));
      check("b1_data", 32'(qget(u1_dat, k)), 32'(8'h30 + k % 4));
      if (k > 0) check("b1_spacing", 32'(qget(u1_cyc, k) - qget(u1_cyc, k - 1)), 32'd2);
    end

    // Single source: 10..13 back to back, bubble, then 14.
    do_reset();
    base[2] = 10; remaining[2] = 5; want = 4'b0100;
    run_outputs("single", 5, 40);
    for (int k = 0; k < 5; k++) begin
      check("single_tid", 32'(qget(out_tid, k)), 32'd2);
      check("single_data", 32'(qget(out_dat, k)), 32'(10 + k));
    end
    for (int k = 1; k < 4; k++)
      check("single_gap", 32'(qget(out_cyc, k) - qget(out_cyc, k - 1)), 32'd1);
    check("single_bubble", 32'(qget(out_cyc, 4) - qget(out_cyc, 3)), 32'd2);

    // All sources valid: TID 0x4,1x4,2x4,3x4,0x4.
    do_reset();
    for (int i = 0; i < NS; i++) begin base[i] = 16 * i; remaining[i] = 100; end
    want = 4'hF;
    run_outputs("rr", 20, 80);
    for (int k = 0; k < 20; k++) begin
      check("rr_tid", 32'(qget(out_tid, k)), 32'((k / 4) % 4));
      check("rr_data", 32'(qget(out_dat, k)), 32'(16 * ((k / 4) % 4) + 4 * (k / 16) + k % 4));
    end

    // Backpressure: 0x42 is held three cycles, then the stream resumes.
    do_reset();
    base[1] = 8'h40; remaining[1] = 8; want = 4'b0010;
    run_outputs("bp_pre", 2, 20);
    m_ready = 1'b0;
    #1;
    check("bp_sready_fill", 32'(s_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("bp_sready", 32'(s_ready), 32'd0);
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_data", 32'(m_data), 32'h42);
      check("bp_tid", 32'(m_tid), 32'd1);
    end
    m_ready = 1'b1;
    run_outputs("bp", 8, 40);
    for (int k = 0; k < 8; k++) begin
      check("bp_seq_data", 32'(qget(out_dat, k)), 32'(8'h40 + k));
      check("bp_seq_tid", 32'(qget(out_tid, k)), 32'd1);
    end
    check("bp_stall_len", 32'(qget(out_cyc, 2) - qget(out_cyc, 1)), 32'd4);
    check("bp_resume", 32'(qget(out_cyc, 3) - qget(out_cyc, 2)), 32'd1);

    // Early release: src1 sends 2, src3 is next (not src0, which asks after src1 drops).
    do_reset();
    base[1] = 8'h10; remaining[1] = 2;
    base[3] = 8'h70; remaining[3] = 3;
    base[0] = 8'h50; remaining[0] = 2;
    want = 4'b1010;
    for (int b = 0; b < 40 && out_tid.size() < 7; b++) begin
      cycle();
      if (nxt[1] == 2) want[0] = 1'b1;
    end
    check("er_count", 32'(out_tid.size() >= 7), 32'd1);
    for (int k = 0; k < 7; k++)
      check("er_tid", 32'(qget(out_tid, k)), 32'((k < 2) ? 1 : (k < 5) ? 3 : 0));
    check("er_data_src3", 32'(qget(out_dat, 2)), 32'h70);

    // Reset while a beat is held: outputs clear, first grant afterwards is src0.
    do_reset();
    for (int i = 0; i < NS; i++) begin base[i] = 16 * i; remaining[i] = 100; end
    want = 4'hF;
    run_outputs("mid_pre", 3, 20);
    check("mid_pre_valid", 32'(m_valid), 32'd1);
    do_reset();
    for (int i = 0; i < NS; i++) begin base[i] = 16 * i + 8; remaining[i] = 100; end
    want = 4'hF;
    run_outputs("mid_post", 1, 10);
    check("mid_first_tid", 32'(qget(out_tid, 0)), 32'd0);
    check("mid_first_data", 32'(qget(out_dat, 0)), 32'd8);

    // Random valids and downstream ready, then drain and account for every beat.
    do_reset();
    rnd = 1'b1; want = 4'hF;
    for (int i = 0; i < NS; i++) begin
      base[i] = 64 * i;
      remaining[i] = $urandom_range(60, 5);
    end
    for (int c = 0; c < 400; c++) begin
      m_ready = ($urandom_range(3, 0) != 0);
      cycle();
    end
    rnd = 1'b0; want = '0; m_ready = 1'b1;
    repeat (10) cycle();
    sent = 0;
    for (int i = 0; i < NS; i++) begin
      check("rand_leftover", 32'(exp_q[i].size()), 32'd0);
      sent += nxt[i];
    end
    check("rand_total", 32'(out_tid.size()), 32'(sent));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
